// File: rtl/lab5_alu_pkg.sv
// Shared width and opcode encoding for the lab5 switch-driven ALU.
package lab5_alu_pkg;

   localparam int unsigned W = 4;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_INC  = 4'd2,
      OP_DEC  = 4'd3,
      OP_AND  = 4'd4,
      OP_OR   = 4'd5,
      OP_XOR  = 4'd6,
      OP_NOT  = 4'd7,
      OP_NAND = 4'd8,
      OP_NOR  = 4'd9,
      OP_XNOR = 4'd10,
      OP_SHL  = 4'd11,
      OP_SHR  = 4'd12,
      OP_ROL  = 4'd13,
      OP_ROR  = 4'd14,
      OP_NEG  = 4'd15
   } opcode_e;

endpackage

// File: rtl/lab5_add4.sv
// 4-bit ripple-carry adder built from a chain of full adders.
module lab5_add4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);

   logic [4:0] carry;

   always_comb begin
      carry    = '0;
      sum      = '0;
      carry[0] = cin;
      for (int unsigned i = 0; i < 4; i++) begin
         sum[i]     = a[i] ^ b[i] ^ carry[i];
         carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
      end
      cout = carry[4];
   end

endmodule

// File: rtl/lab5_alu.sv
// 16-function 4-bit ALU with a registered result and carry/flag bit.
module lab5_alu
   import lab5_alu_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   input  logic [3:0]   select,
   output logic [W-1:0] out,
   output logic         c_out
);

   opcode_e      op;
   logic [W-1:0] add_a;
   logic [W-1:0] add_b;
   logic         add_cin;
   logic [W-1:0] add_sum;
   logic         add_cout;
   logic [W-1:0] res;
   logic         res_c;

   assign op = opcode_e'(select);

   // All arithmetic shares one adder; SUB/NEG use two's complement via inverted B and cin=1.
   always_comb begin
      add_a   = x;
      add_b   = y;
      add_cin = 1'b0;
      case (op)
         OP_SUB: begin
            add_b   = ~y;
            add_cin = 1'b1;
         end
         OP_INC: add_b = 4'b0001;
         OP_DEC: add_b = 4'b1111;
         OP_NEG: begin
            add_a   = '0;
            add_b   = ~x;
            add_cin = 1'b1;
         end
         default: ;
      endcase
   end

   lab5_add4 u_add4 (
      .a    (add_a),
      .b    (add_b),
      .cin  (add_cin),
      .sum  (add_sum),
      .cout (add_cout)
   );

   always_comb begin
      res   = '0;
      res_c = 1'b0;
      case (op)
         OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_NEG: begin
            res   = add_sum;
            res_c = add_cout;
         end
         OP_AND:  res = x & y;
         OP_OR:   res = x | y;
         OP_XOR:  res = x ^ y;
         OP_NOT:  res = ~x;
         OP_NAND: res = ~(x & y);
         OP_NOR:  res = ~(x | y);
         OP_XNOR: res = ~(x ^ y);
         OP_SHL: begin
            res   = {x[2:0], 1'b0};
            res_c = x[3];
         end
         OP_SHR: begin
            res   = {1'b0, x[3:1]};
            res_c = x[0];
         end
         OP_ROL: begin
            res   = {x[2:0], x[3]};
            res_c = x[3];
         end
         OP_ROR: begin
            res   = {x[0], x[3:1]};
            res_c = x[0];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out   <= '0;
         c_out <= 1'b0;
      end else begin
         out   <= res;
         c_out <= res_c;
      end
   end

endmodule

// File: tb/tb_lab5_alu.sv
// Directed and exhaustive checks of lab5_alu against hand values and a behavioural model.
module tb_lab5_alu;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] x = '0;
   logic [3:0] y = '0;
   logic [3:0] select = '0;
   logic [3:0] out;
   logic       c_out;

   int unsigned errors = 0;
   int unsigned checks = 0;

   lab5_alu dut (
      .clk    (clk),
      .reset  (reset),
      .x      (x),
      .y      (y),
      .select (select),
      .out    (out),
      .c_out  (c_out)
   );

   always #5 clk = ~clk;

   // Behavioural reference built from integer arithmetic, not from the adder structure.
   function automatic logic [4:0] ref_alu(input logic [3:0] a, input logic [3:0] b,
                                          input logic [3:0] s);
      int ia, ib;
      logic [3:0] r;
      logic c;
      ia = int'(a);
      ib = int'(b);
      r  = '0;
      c  = 1'b0;
      case (s)
         4'd0:  begin r = 4'((ia + ib) % 16); c = (ia + ib) > 15; end
         4'd1:  begin r = 4'((ia - ib + 16) % 16); c = ia >= ib; end
         4'd2:  begin r = 4'((ia + 1) % 16); c = ia == 15; end
         4'd3:  begin r = 4'((ia + 15) % 16); c = ia != 0; end
         4'd4:  r = a & b;
         4'd5:  r = a | b;
         4'd6:  r = a ^ b;
         4'd7:  r = ~a;
         4'd8:  r = ~(a & b);
         4'd9:  r = ~(a | b);
         4'd10: r = ~(a ^ b);
         4'd11: begin r = 4'((ia * 2) % 16); c = ia >= 8; end
         4'd12: begin r = 4'(ia / 2); c = (ia % 2) == 1; end
         4'd13: begin r = 4'(((ia * 2) % 16) + ia / 8); c = ia >= 8; end
         4'd14: begin r = 4'(ia / 2 + 8 * (ia % 2)); c = (ia % 2) == 1; end
         default: begin r = 4'((16 - ia) % 16); c = ia == 0; end
      endcase
      return {c, r};
   endfunction

   task automatic step(input logic r, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] s);
      @(negedge clk);
      reset  = r;
      x      = a;
      y      = b;
      select = s;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 4'd15, 4'd15, 4'd0);
         checks++;
         if (out !== 4'd0 || c_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold[%0d]: got out=%0d c=%b, want out=0 c=0", i, out, c_out);
         end
      end
      step(1'b0, 4'd15, 4'd15, 4'd0);
      checks++;
      if (out !== 4'd14 || c_out !== 1'b1) begin
         errors++;
         $display("FAIL reset_release: got out=%0d c=%b, want out=14 c=1", out, c_out);
      end
   endtask

   task automatic test_add_sub;
      logic [3:0] xa[3] = '{4'd9, 4'd3, 4'd5};
      logic [3:0] ya[3] = '{4'd8, 4'd5, 4'd5};
      logic [3:0] sa[3] = '{4'd0, 4'd1, 4'd1};
      logic [3:0] eo[3] = '{4'd1, 4'd14, 4'd0};
      logic       ec[3] = '{1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 3; i++) begin
         step(1'b0, xa[i], ya[i], sa[i]);
         checks++;
         if (out !== eo[i] || c_out !== ec[i]) begin
            errors++;
            $display("FAIL add_sub[%0d]: got out=%0d c=%b, want out=%0d c=%b",
                     i, out, c_out, eo[i], ec[i]);
         end
      end
   endtask

   task automatic test_inc_dec_neg;
      logic [3:0] xa[4] = '{4'd15, 4'd0, 4'd0, 4'd1};
      logic [3:0] sa[4] = '{4'd2, 4'd3, 4'd15, 4'd15};
      logic [3:0] eo[4] = '{4'd0, 4'd15, 4'd0, 4'd15};
      logic       ec[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 4; i++) begin
         step(1'b0, xa[i], 4'd6, sa[i]);
         checks++;
         if (out !== eo[i] || c_out !== ec[i]) begin
            errors++;
            $display("FAIL inc_dec_neg[%0d]: got out=%0d c=%b, want out=%0d c=%b",
                     i, out, c_out, eo[i], ec[i]);
         end
      end
   endtask

   task automatic test_logic;
      logic [3:0] sa[7] = '{4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd7};
      logic [3:0] eo[7] = '{4'b1000, 4'b1110, 4'b0110, 4'b0111, 4'b0001, 4'b1001, 4'b0011};
      for (int i = 0; i < 7; i++) begin
         step(1'b0, 4'b1100, 4'b1010, sa[i]);
         checks++;
         if (out !== eo[i] || c_out !== 1'b0) begin
            errors++;
            $display("FAIL logic_sel%0d: got out=%b c=%b, want out=%b c=0",
                     sa[i], out, c_out, eo[i]);
         end
      end
   endtask

   task automatic test_shift;
      logic [3:0] sa[4] = '{4'd11, 4'd12, 4'd13, 4'd14};
      logic [3:0] eo[4] = '{4'b0010, 4'b0100, 4'b0011, 4'b1100};
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 4'b1001, 4'b0110, sa[i]);
         checks++;
         if (out !== eo[i] || c_out !== 1'b1) begin
            errors++;
            $display("FAIL shift_sel%0d: got out=%b c=%b, want out=%b c=1",
                     sa[i], out, c_out, eo[i]);
         end
      end
   endtask

   task automatic test_mid_reset;
      step(1'b0, 4'd7, 4'd9, 4'd0);
      step(1'b1, 4'd15, 4'd15, 4'd5);
      checks++;
      if (out !== 4'd0 || c_out !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: got out=%0d c=%b, want out=0 c=0", out, c_out);
      end
      reset = 1'b0;
   endtask

   task automatic test_back_to_back;
      logic [3:0] a, b;
      logic [4:0] e;
      for (int n = 0; n < 32; n++) begin
         a = 4'($urandom_range(15));
         b = 4'($urandom_range(15));
         e = ref_alu(a, b, 4'(n % 16));
         step(1'b0, a, b, 4'(n % 16));
         checks++;
         if ({c_out, out} !== e) begin
            errors++;
            $display("FAIL b2b[%0d] sel=%0d x=%0d y=%0d: got out=%0d c=%b, want out=%0d c=%b",
                     n, n % 16, a, b, out, c_out, e[3:0], e[4]);
         end
      end
   endtask

   task automatic test_exhaustive;
      logic [4:0] e;
      for (int s = 0; s < 16; s++)
         for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++) begin
               e = ref_alu(4'(a), 4'(b), 4'(s));
               step(1'b0, 4'(a), 4'(b), 4'(s));
               checks++;
               if ({c_out, out} !== e) begin
                  errors++;
                  $display("FAIL sweep sel=%0d x=%0d y=%0d: got out=%0d c=%b, want out=%0d c=%b",
                           s, a, b, out, c_out, e[3:0], e[4]);
               end
            end
   endtask

   initial begin
      test_reset();
      test_add_sub();
      test_inc_dec_neg();
      test_logic();
      test_shift();
      test_mid_reset();
      test_back_to_back();
      test_exhaustive();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
